// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter, runs the request/acknowledge fetch
// to instruction memory, holds the fetched word while the core executes it,
// and selects the next PC from the core's control outputs.
// Every output is registered and is computed from the next-state values, so
// each output changes on the same edge as the state it reflects.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        exec_done,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_idx,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        halt,
  output logic        halted,
  output logic        misaligned,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    HALT  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] pc_nxt_s;
  logic [31:0] pc_plus4_r;
  logic [31:0] instr_r;
  logic [31:0] instr_nxt_s;
  logic [31:0] count_r;
  logic [31:0] count_nxt_s;
  logic        mis_r;
  logic        mis_nxt_s;
  logic [31:0] target_s;
  logic        imem_req_r;
  logic [31:0] imem_addr_r;
  logic        instr_valid_r;
  logic        halted_r;

  // Next-PC selection: jr beats jump beats a taken branch beats sequential.
  // Branch offsets are in words, so they are sign-extended and scaled by 4;
  // the jump keeps the 256 MB region of the following instruction.
  function automatic logic [31:0] calc_target(
    input logic [31:0] seq_pc,
    input logic        f_jr,
    input logic [31:0] f_jr_addr,
    input logic        f_jump,
    input logic [25:0] f_jump_idx,
    input logic        f_branch,
    input logic [15:0] f_branch_imm
  );
    logic [31:0] result;
    if (f_jr) begin
      result = f_jr_addr;
    end else if (f_jump) begin
      result = {seq_pc[31:28], f_jump_idx, 2'b00};
    end else if (f_branch) begin
      result = seq_pc + {{14{f_branch_imm[15]}}, f_branch_imm, 2'b00};
    end else begin
      result = seq_pc;
    end
    return result;
  endfunction

  // Next-state logic: fetch handshake, instruction retirement, halt and
  // misalignment trapping.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    instr_nxt_s = instr_r;
    count_nxt_s = count_r;
    mis_nxt_s   = mis_r;
    target_s    = calc_target(pc_plus4_r, jr, jr_addr, jump, jump_idx,
                              branch_taken, branch_imm);
    case (state_r)
      IDLE: begin
        state_nxt_s = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          instr_nxt_s = imem_rdata;
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      EXEC: begin
        if (exec_done) begin
          if (halt) begin
            count_nxt_s = count_r + 32'd1;
            state_nxt_s = HALT;
          end else if (target_s[1:0] != 2'b00) begin
            // Trap without retiring: pc keeps the offending instruction.
            mis_nxt_s   = 1'b1;
            state_nxt_s = ERR;
          end else begin
            pc_nxt_s    = target_s;
            count_nxt_s = count_r + 32'd1;
            state_nxt_s = FETCH;
          end
        end else begin
          state_nxt_s = EXEC;
        end
      end
      HALT: begin
        state_nxt_s = HALT;
      end
      ERR: begin
        state_nxt_s = ERR;
      end
      default: begin
        // Unreachable encodings restart the sequence from a clean state.
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, PC, instruction and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      pc_plus4_r    <= RESET_PC + 32'd4;
      instr_r       <= 32'd0;
      count_r       <= 32'd0;
      mis_r         <= 1'b0;
      imem_req_r    <= 1'b0;
      imem_addr_r   <= 32'd0;
      instr_valid_r <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      pc_r          <= pc_nxt_s;
      pc_plus4_r    <= pc_nxt_s + 32'd4;
      instr_r       <= instr_nxt_s;
      count_r       <= count_nxt_s;
      mis_r         <= mis_nxt_s;
      imem_req_r    <= (state_nxt_s == FETCH);
      imem_addr_r   <= (state_nxt_s == FETCH) ? pc_nxt_s : 32'd0;
      instr_valid_r <= (state_nxt_s == EXEC);
      halted_r      <= (state_nxt_s == HALT);
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = imem_addr_r;
  assign instr_valid = instr_valid_r;
  assign instr       = instr_r;
  assign pc_out      = pc_r;
  assign pc_plus4    = pc_plus4_r;
  assign halted      = halted_r;
  assign misaligned  = mis_r;
  assign instr_count = count_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations, then randomized stimulus compared every cycle against a
// behavioural model of the sequencer.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        exec_done;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_idx;
  logic        jr;
  logic [31:0] jr_addr;
  logic        halt;
  logic        halted;
  logic        misaligned;
  logic [31:0] instr_count;

  int n_tests = 0;
  int n_fail  = 0;

  // model: phase of the sequencer plus architectural state
  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_EXEC  = 2;
  localparam int M_HALT  = 3;
  localparam int M_ERR   = 4;
  int          m_mode  = M_IDLE;
  logic [31:0] m_pc    = 32'd0;
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_cnt   = 32'd0;
  logic        m_mis   = 1'b0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr),
    .pc_out(pc_out), .pc_plus4(pc_plus4),
    .exec_done(exec_done), .branch_taken(branch_taken),
    .branch_imm(branch_imm), .jump(jump), .jump_idx(jump_idx),
    .jr(jr), .jr_addr(jr_addr), .halt(halt),
    .halted(halted), .misaligned(misaligned), .instr_count(instr_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the sequencer must do on one clock edge with the current inputs.
  task automatic model_update();
    logic [31:0] p4;
    logic [31:0] nxt;
    int          off;
    if (!rst_n) begin
      m_mode = M_IDLE; m_pc = 32'd0; m_instr = 32'd0; m_cnt = 32'd0; m_mis = 1'b0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_FETCH;
    end else if (m_mode == M_FETCH) begin
      if (imem_ack) begin
        m_instr = imem_rdata;
        m_mode  = M_EXEC;
      end
    end else if (m_mode == M_EXEC && exec_done) begin
      if (halt) begin
        m_cnt  = m_cnt + 32'd1;
        m_mode = M_HALT;
      end else begin
        p4  = m_pc + 32'd4;
        off = $signed(branch_imm);
        if (jr)                nxt = jr_addr;
        else if (jump)         nxt = (p4 & 32'hF000_0000) | ({6'd0, jump_idx} << 2);
        else if (branch_taken) nxt = p4 + 32'(off * 4);
        else                   nxt = p4;
        if (nxt % 32'd4 != 32'd0) begin
          m_mis  = 1'b1;
          m_mode = M_ERR;
        end else begin
          m_pc   = nxt;
          m_cnt  = m_cnt + 32'd1;
          m_mode = M_FETCH;
        end
      end
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare_model();
    chk("imem_req",    {31'd0, imem_req},    {31'd0, m_mode == M_FETCH});
    chk("imem_addr",   imem_addr,            (m_mode == M_FETCH) ? m_pc : 32'd0);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_mode == M_EXEC});
    chk("halted",      {31'd0, halted},      {31'd0, m_mode == M_HALT});
    chk("misaligned",  {31'd0, misaligned},  {31'd0, m_mis});
    chk("instr",       instr,                m_instr);
    chk("pc_out",      pc_out,               m_pc);
    chk("pc_plus4",    pc_plus4,             m_pc + 32'd4);
    chk("instr_count", instr_count,          m_cnt);
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic step();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clr();
    imem_ack = 1'b0; exec_done = 1'b0; branch_taken = 1'b0;
    jump = 1'b0; jr = 1'b0; halt = 1'b0;
  endtask

  task automatic do_fetch(input int waits, input logic [31:0] word);
    clr();
    repeat (waits) step();
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack = 1'b0;
  endtask

  // Caller sets the control inputs; this retires the instruction.
  task automatic do_exec();
    exec_done = 1'b1;
    step();
    clr();
  endtask

  logic [31:0] cnt_before;
  logic [31:0] tmp;

  initial begin
    rst_n = 1'b0; clr();
    imem_rdata = 32'd0; branch_imm = 16'd0; jump_idx = 26'd0; jr_addr = 32'd0;
    @(posedge clk);
    model_update();
    #1;
    step();
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_pc",    pc_out,            32'h0000_0000);
    chk("rst_pc4",   pc_plus4,          32'h0000_0004);
    chk("rst_count", instr_count,       32'd0);

    // slow memory: ack in the third FETCH cycle
    rst_n = 1'b1;
    step();
    chk("fetch0_req",  {31'd0, imem_req}, 32'd1);
    chk("fetch0_addr", imem_addr,         32'h0000_0000);
    clr();
    step();
    step();
    chk("fetch0_wait", {31'd0, imem_req}, 32'd1);
    do_fetch(0, 32'h1234_5678);
    chk("exec0_valid", {31'd0, instr_valid}, 32'd1);
    chk("exec0_instr", instr,                32'h1234_5678);
    step();
    chk("exec0_count", instr_count, 32'd0);
    do_exec();
    chk("seq_addr1", imem_addr, 32'h0000_0004);

    // three more sequential instructions with same-cycle ack
    for (int k = 2; k <= 4; k++) begin
      do_fetch(0, 32'hA000_0000 + 32'(k));
      do_exec();
      chk("seq_addr", imem_addr, 32'(k * 4));
    end
    chk("seq_count", instr_count, 32'd4);

    // branch backward then forward around 0x100
    do_fetch(0, 32'h0); jr = 1'b1; jr_addr = 32'h0000_0100; do_exec();
    chk("jr_0x100", imem_addr, 32'h0000_0100);
    do_fetch(0, 32'h1); branch_taken = 1'b1; branch_imm = 16'hFFFE; do_exec();
    chk("branch_back", imem_addr, 32'h0000_00FC);
    do_fetch(0, 32'h2); branch_taken = 1'b1; branch_imm = 16'h0003; do_exec();
    chk("branch_fwd", imem_addr, 32'h0000_010C);

    // jump keeps the upper region; jr beats jump
    do_fetch(0, 32'h3); jr = 1'b1; jr_addr = 32'hF000_0010; do_exec();
    do_fetch(0, 32'h4); jump = 1'b1; jump_idx = 26'h0000040; do_exec();
    chk("jump", imem_addr, 32'hF000_0100);
    do_fetch(0, 32'h5); jump = 1'b1; jr = 1'b1; jr_addr = 32'h0000_0200; do_exec();
    chk("jr_over_jump", imem_addr, 32'h0000_0200);

    // misaligned register jump traps
    do_fetch(1, 32'h6);
    cnt_before = instr_count;
    jr = 1'b1; jr_addr = 32'h0000_0202; do_exec();
    chk("mis_flag",  {31'd0, misaligned}, 32'd1);
    chk("mis_req",   {31'd0, imem_req},   32'd0);
    chk("mis_pc",    pc_out,              32'h0000_0200);
    chk("mis_count", instr_count,         cnt_before);
    imem_ack = 1'b1; exec_done = 1'b1;
    repeat (3) step();
    clr();
    chk("mis_stuck", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst2_mis",   {31'd0, misaligned}, 32'd0);
    chk("rst2_pc",    pc_out,              32'h0000_0000);
    chk("rst2_instr", instr,               32'h0000_0000);
    chk("rst2_count", instr_count,         32'd0);
    step();
    chk("rst2_fetch", imem_addr, 32'h0000_0000);

    // halt retires and freezes the sequencer
    do_fetch(1, 32'h7); halt = 1'b1; jr = 1'b1; jr_addr = 32'h0000_0202; do_exec();
    chk("halt_flag",  {31'd0, halted},      32'd1);
    chk("halt_count", instr_count,          32'd1);
    imem_ack = 1'b1; exec_done = 1'b1;
    repeat (3) step();
    clr();
    chk("halt_req",   {31'd0, imem_req},    32'd0);
    chk("halt_valid", {31'd0, instr_valid}, 32'd0);
    chk("halt_stay",  {31'd0, halted},      32'd1);

    // reset in the middle of a fetch
    rst_n = 1'b0; step();
    rst_n = 1'b1; step();
    chk("midfetch_req", {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0; step();
    chk("midfetch_rst", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b1;

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst_n        = ($urandom_range(0, 149) != 0);
      imem_ack     = ($urandom_range(0, 2) == 0);
      imem_rdata   = $urandom;
      exec_done    = ($urandom_range(0, 2) == 0);
      branch_taken = ($urandom_range(0, 1) == 0);
      branch_imm   = 16'($urandom);
      jump         = ($urandom_range(0, 3) == 0);
      jump_idx     = 26'($urandom);
      jr           = ($urandom_range(0, 7) == 0);
      tmp          = $urandom;
      jr_addr      = ($urandom_range(0, 15) == 0) ? tmp : {tmp[31:2], 2'b00};
      halt         = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
